// File: rtl/dmem_responder_pkg.sv
// Shared func3 codes, FSM states and extension helpers for dmem_responder.
package dmem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_t;

  function automatic logic [31:0] ext8(
    input logic [7:0] b,
    input logic       s
  );
    return {{24{s & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(
    input logic [15:0] h,
    input logic        s
  );
    return {{16{s & h[15]}}, h};
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core (master) and dmem_responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_func3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_func3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder_ls_align.sv
// Byte-lane steering and load extension; MISALIGN_TRAP_EN enables the
// misalignment flag, otherwise low address bits are simply truncated.
module dmem_responder_ls_align
  import dmem_responder_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic        o_invalid
);

  logic        w_sb, w_sh, w_sw;
  logic        w_lb, w_lh, w_lw, w_lbu, w_lhu;
  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_sb  =  i_we & (i_func3 == F3_SB);
  assign w_sh  =  i_we & (i_func3 == F3_SH);
  assign w_sw  =  i_we & (i_func3 == F3_SW);
  assign w_lb  = ~i_we & (i_func3 == F3_LB);
  assign w_lh  = ~i_we & (i_func3 == F3_LH);
  assign w_lw  = ~i_we & (i_func3 == F3_LW);
  assign w_lbu = ~i_we & (i_func3 == F3_LBU);
  assign w_lhu = ~i_we & (i_func3 == F3_LHU);

  assign w_shift = i_rdata >> {i_addr, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_be      = '0;
    o_wdata   = '0;
    o_rdata   = '0;
    o_invalid = 1'b0;
    unique case (1'b1)
      w_sb: begin
        o_be    = 4'b0001 << i_addr;
        o_wdata = {4{i_wdata[7:0]}};
      end
      w_sh: begin
        o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      w_sw: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
      w_lb:    o_rdata = ext8(w_byte, 1'b1);
      w_lbu:   o_rdata = ext8(w_byte, 1'b0);
      w_lh:    o_rdata = ext16(w_half, 1'b1);
      w_lhu:   o_rdata = ext16(w_half, 1'b0);
      w_lw:    o_rdata = i_rdata;
      default: o_invalid = 1'b1;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign o_misalign = ((i_func3[1:0] == 2'b01) & i_addr[0])
                    | ((i_func3[1:0] == 2'b10) & (|i_addr));
`else
  assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: IDLE/WAIT/RESP handshake FSM, wait-state counter
// and word storage. Optional MISALIGN_TRAP_EN turns misaligned accesses into faults.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int IDXW = $clog2(DEPTH_WORDS);

  dmem_state_t r_state, w_next;
  logic        r_we;
  logic [2:0]  r_func3;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_cnt;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic            w_idle, w_ready, w_accept, w_commit, w_wr;
  logic            w_we, w_oor, w_err, w_mis, w_inv;
  logic [2:0]      w_func3;
  logic [31:0]     w_addr, w_wdata, w_word, w_wdsh, w_ext;
  logic [3:0]      w_be;
  logic [IDXW-1:0] w_idx;

  assign w_idle   = (r_state == DMEM_IDLE);
  assign w_ready  = w_idle & ~rst;
  assign w_accept = bus.req_valid & w_ready;

  // Zero wait states commit on the accept edge, straight from the inputs.
  assign w_we    = w_idle ? bus.req_we    : r_we;
  assign w_func3 = w_idle ? bus.req_func3 : r_func3;
  assign w_addr  = w_idle ? bus.req_addr  : r_addr;
  assign w_wdata = w_idle ? bus.req_wdata : r_wdata;

  assign w_commit = (w_accept & (WAIT_STATES == 0))
                  | ((r_state == DMEM_WAIT) & (r_cnt == 4'd0));

  assign w_idx  = w_addr[IDXW+1:2];
  assign w_oor  = (w_addr[31:2] >= 30'(DEPTH_WORDS));
  assign w_word = w_oor ? '0 : r_mem[w_idx];
  assign w_err  = w_inv | w_oor | w_mis;
  assign w_wr   = w_commit & w_we & ~w_err;

  dmem_responder_ls_align u_ls_align (
    .i_we       (w_we),
    .i_func3    (w_func3),
    .i_addr     (w_addr[1:0]),
    .i_wdata    (w_wdata),
    .i_rdata    (w_word),
    .o_be       (w_be),
    .o_wdata    (w_wdsh),
    .o_rdata    (w_ext),
    .o_misalign (w_mis),
    .o_invalid  (w_inv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DMEM_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      DMEM_IDLE: if (w_accept)
        w_next = (WAIT_STATES == 0) ? DMEM_RESP : DMEM_WAIT;
      DMEM_WAIT: if (r_cnt == 4'd0) w_next = DMEM_RESP;
      DMEM_RESP: w_next = DMEM_IDLE;
      default:   w_next = DMEM_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = w_ready;
    bus.rsp_valid = (r_state == DMEM_RESP);
    bus.rsp_rdata = r_rdata;
    bus.rsp_err   = r_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_func3 <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_func3 <= bus.req_func3;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_cnt   <= 4'(WAIT_STATES);
      end else if ((r_state == DMEM_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_rdata <= (w_commit & ~w_err & ~w_we) ? w_ext : '0;
      r_err   <= w_commit & w_err;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdsh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus1();
  dmem_responder_if bus3();

  logic        tv = 1'b0, twe = 1'b0, tsel = 1'b0;
  logic [2:0]  tf3 = '0;
  logic [31:0] taddr = '0, twd = '0;

  assign bus1.req_valid = tv & ~tsel;
  assign bus1.req_we    = twe;
  assign bus1.req_func3 = tf3;
  assign bus1.req_addr  = taddr;
  assign bus1.req_wdata = twd;
  assign bus3.req_valid = tv & tsel;
  assign bus3.req_we    = twe;
  assign bus3.req_func3 = tf3;
  assign bus3.req_addr  = taddr;
  assign bus3.req_wdata = twd;

  logic        o_ready, o_valid, o_err;
  logic [31:0] o_rdata;
  always_comb begin
    o_ready = tsel ? bus3.req_ready : bus1.req_ready;
    o_valid = tsel ? bus3.rsp_valid : bus1.rsp_valid;
    o_rdata = tsel ? bus3.rsp_rdata : bus1.rsp_rdata;
    o_err   = tsel ? bus3.rsp_err   : bus1.rsp_err;
  end

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] mem_m [int];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: RV32I load/store semantics on a word array.
  task automatic ref_op(input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    int wi;
    int sz;
    bit inv, oor, mis;
    logic [31:0] w;
    logic [31:0] v;
    wi  = int'(a >> 2);
    sz  = int'(f3[1:0]);
    inv = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    oor = (a >> 2) >= 32'd1024;
`ifdef MISALIGN_TRAP_EN
    mis = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    rd = 32'd0;
    er = inv || oor || mis;
    if (er) return;
    w = mem_m.exists(wi) ? mem_m[wi] : 32'hxxxxxxxx;
    if (we) begin
      if (sz == 0) w[8*a[1:0] +: 8] = wd[7:0];
      else if (sz == 1) w[16*a[1] +: 16] = wd[15:0];
      else w = wd;
      mem_m[wi] = w;
    end else begin
      if (sz == 0) begin
        v = (w >> (8 * a[1:0])) & 32'hFF;
        if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
      end else if (sz == 1) begin
        v = (w >> (16 * a[1])) & 32'hFFFF;
        if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
      end else begin
        v = w;
      end
      rd = v;
    end
  endtask

  task automatic access(input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat);
    @(negedge clk);
    check("ready_idle", {31'd0, o_ready}, 32'd1);
    tv = 1'b1; twe = we; tf3 = f3; taddr = a; twd = wd;
    @(posedge clk);
    #1;
    tv = 1'b0;
    twe = 1'($urandom); tf3 = 3'($urandom);
    taddr = $urandom; twd = $urandom;
    lat = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        lat = i; rd = o_rdata; er = o_err;
        break;
      end
    end
    if (lat == 0) check("rsp_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    check("pulse_width", {31'd0, o_valid}, 32'd0);
  endtask

  task automatic op(input string tag, input bit we, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    output logic [31:0] rd);
    logic [31:0] erd;
    logic        eer, er;
    int lat;
    access(we, f3, a, wd, rd, er, lat);
    ref_op(we, f3, a, wd, erd, eer);
    check({tag, "_data"}, rd, erd);
    check({tag, "_err"}, {31'd0, er}, {31'd0, eer});
    check({tag, "_lat"}, lat, 32'd2);
  endtask

  initial begin
    logic [31:0] rd, rd3;
    logic        er3;
    int lat3, seen;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, o_ready}, 32'd1);

    op("sw100", 1, 3'b010, 32'h100, 32'hDEADBEEF, rd);
    op("lw100", 0, 3'b010, 32'h100, 32'h0, rd);
    check("lw100_const", rd, 32'hDEADBEEF);

    op("sw100b", 1, 3'b010, 32'h100, 32'h11223344, rd);
    op("sb103", 1, 3'b000, 32'h103, 32'h00000080, rd);
    op("lb103", 0, 3'b000, 32'h103, 32'h0, rd);
    check("lb103_const", rd, 32'hFFFFFF80);
    op("lbu103", 0, 3'b100, 32'h103, 32'h0, rd);
    check("lbu103_const", rd, 32'h00000080);
    op("lw100c", 0, 3'b010, 32'h100, 32'h0, rd);
    check("lw100c_const", rd, 32'h80223344);

    op("sw200", 1, 3'b010, 32'h200, 32'hCAFE1234, rd);
    op("sh202", 1, 3'b001, 32'h202, 32'h00008001, rd);
    op("lh202", 0, 3'b001, 32'h202, 32'h0, rd);
    check("lh202_const", rd, 32'hFFFF8001);
    op("lhu202", 0, 3'b101, 32'h202, 32'h0, rd);
    check("lhu202_const", rd, 32'h00008001);
    op("lw200", 0, 3'b010, 32'h200, 32'h0, rd);
    check("lw200_const", rd, 32'h80011234);

    op("lw_oor", 0, 3'b010, 32'h1000, 32'h0, rd);
    op("ld_f3_011", 0, 3'b011, 32'h100, 32'h0, rd);
    op("st_f3_011", 1, 3'b011, 32'h100, 32'hFFFFFFFF, rd);
    op("sw_oor", 1, 3'b010, 32'h1004, 32'h12345678, rd);
    op("lw100d", 0, 3'b010, 32'h100, 32'h0, rd);
    op("lw102", 0, 3'b010, 32'h102, 32'h0, rd);
`ifdef MISALIGN_TRAP_EN
    check("lw102_const", rd, 32'h0);
`else
    check("lw102_const", rd, 32'h80223344);
`endif

    // Store interrupted by reset on the WAIT_STATES=3 instance.
    tsel = 1'b1;
    access(1, 3'b010, 32'h300, 32'h00000055, rd3, er3, lat3);
    check("ws3_sw_lat", lat3, 32'd4);
    @(negedge clk);
    tv = 1'b1; twe = 1'b1; tf3 = 3'b010; taddr = 32'h300; twd = 32'hAA;
    @(posedge clk);
    #1;
    tv = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, o_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, o_ready}, 32'd1);
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (o_valid) seen++;
    end
    check("rst_no_strobe", seen, 32'd0);
    access(0, 3'b010, 32'h300, 32'h0, rd3, er3, lat3);
    check("ws3_lw_data", rd3, 32'h00000055);
    check("ws3_lw_lat", lat3, 32'd4);
    tsel = 1'b0;

    // Storage survives reset on the WAIT_STATES=1 instance.
    op("lw200_post_rst", 0, 3'b010, 32'h200, 32'h0, rd);

    for (int i = 0; i < 8; i++)
      op("init", 1, 3'b010, 32'h400 + 32'(4 * i), $urandom, rd);
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 15) == 0)
        a = 32'h1000 + 32'($urandom_range(0, 4095));
      else
        a = 32'h400 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      op("rand", 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, rd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
